toast_branch_unit: RTL

- Parametrised EX-stage branch resolution unit; successor to the combinational branch-target generator.
- Computes the PC-relative or register-offset target, evaluates the RV32I conditional compare, and checks the result against the fetch-stage prediction.
- Registers a redirect request toward fetch with a valid/ready handshake, holding it until fetch accepts it or a flush clears it.

---
 rtl/toast_branch_unit.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/toast_branch_unit.sv
// toast_branch_unit: EX-stage branch resolution.
// Computes the branch target and the RV32I compare result, checks them against
// the fetch prediction, and registers a redirect request toward fetch. A
// redirect is held until fetch accepts it or a flush discards it.
// Optional feature: define TOAST_BRANCH_MISALIGN_EN to add misalign_o. A taken
// branch whose target is not instruction-aligned is then flagged, and no
// redirect is raised for it.

`ifndef PC_RELATIVE
`define PC_RELATIVE 2'b01
`endif
`ifndef REG_OFFSET
`define REG_OFFSET 2'b10
`endif

module toast_branch_unit #(
  parameter int XLEN       = 32,
  parameter int ILEN_BYTES = 4
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      branch_op_i,
  input  logic            cond_en_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            pred_taken_i,
  input  logic [XLEN-1:0] pred_target_i,
  output logic            res_valid_o,
  output logic            taken_o,
  output logic [XLEN-1:0] link_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
`ifdef TOAST_BRANCH_MISALIGN_EN
  output logic            misalign_o,
`endif
  input  logic            redirect_ready_i
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    RESULT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] ilen_step = XLEN'(ILEN_BYTES);
  localparam logic [XLEN-1:0] lsb_clear = ~XLEN'(1);

  state_t state_reg, state_next;

  logic            is_pc_rel;
  logic            is_reg_off;
  logic [XLEN-1:0] pc_target;
  logic [XLEN-1:0] reg_target;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fall_through;
  logic [XLEN-1:0] actual_pc;
  logic            cmp;
  logic            taken;
  logic            mispredict;
  logic            redirect_raise;
  logic            accept;

  logic            taken_reg;
  logic [XLEN-1:0] link_reg;
  logic [XLEN-1:0] redirect_pc_reg;

  // Target generation: PC-relative or register+offset with bit 0 cleared.
  always_comb begin
    is_pc_rel    = (branch_op_i == `PC_RELATIVE);
    is_reg_off   = (branch_op_i == `REG_OFFSET);
    pc_target    = pc_i + imm_i;
    reg_target   = (rs1_i + imm_i) & lsb_clear;
    target       = is_reg_off ? reg_target : pc_target;
    fall_through = pc_i + ilen_step;
  end

  // Conditional compare; 010/011 are not branch encodings and never take.
  always_comb begin
    case (funct3_i)
      3'b000:  cmp = (rs1_i == rs2_i);
      3'b001:  cmp = (rs1_i != rs2_i);
      3'b100:  cmp = ($signed(rs1_i) <  $signed(rs2_i));
      3'b101:  cmp = ($signed(rs1_i) >= $signed(rs2_i));
      3'b110:  cmp = (rs1_i <  rs2_i);
      3'b111:  cmp = (rs1_i >= rs2_i);
      default: cmp = 1'b0;
    endcase
  end

  // Direction, restart address and misprediction detection.
  always_comb begin
    taken      = (is_pc_rel | is_reg_off) & (cond_en_i ? cmp : 1'b1);
    actual_pc  = taken ? target : fall_through;
    // The predicted target only matters when the branch is actually taken.
    mispredict = (taken != pred_taken_i) | (taken & (target != pred_target_i));
  end

`ifdef TOAST_BRANCH_MISALIGN_EN
  localparam logic [XLEN-1:0] align_mask = XLEN'(ILEN_BYTES - 1);

  logic misaligned;
  logic misalign_reg;

  // Misaligned taken targets trap instead of redirecting fetch.
  always_comb begin
    misaligned     = taken & ((target & align_mask) != '0);
    redirect_raise = mispredict & ~misaligned;
  end
`else
  // Without the alignment check every misprediction redirects.
  always_comb begin
    redirect_raise = mispredict;
  end
`endif

  // Handshake: blocked only while a redirect waits for fetch.
  always_comb begin
    ready_o = ~res_valid_o | ~redirect_o | redirect_ready_i;
    accept  = valid_i & ready_o & ~flush_i;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: flush wins, then a new acceptance, then a still-pending redirect.
  always_comb begin
    state_next = state_reg;
    if (flush_i) begin
      state_next = EMPTY;
    end else if (accept) begin
      state_next = redirect_raise ? HOLD : RESULT;
    end else if ((state_reg == HOLD) && !redirect_ready_i) begin
      state_next = HOLD;
    end else begin
      state_next = EMPTY;
    end
  end

  // Outputs decoded from state.
  always_comb begin
    res_valid_o = (state_reg != EMPTY);
    redirect_o  = (state_reg == HOLD);
`ifdef TOAST_BRANCH_MISALIGN_EN
    misalign_o  = misalign_reg & (state_reg != EMPTY);
`endif
  end

  // Result payload, captured only when an instruction is accepted so a held
  // redirect keeps stable values.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      taken_reg       <= 1'b0;
      link_reg        <= '0;
      redirect_pc_reg <= '0;
`ifdef TOAST_BRANCH_MISALIGN_EN
      misalign_reg    <= 1'b0;
`endif
    end else if (accept) begin
      taken_reg       <= taken;
      link_reg        <= fall_through;
      redirect_pc_reg <= actual_pc;
`ifdef TOAST_BRANCH_MISALIGN_EN
      misalign_reg    <= misaligned;
`endif
    end
  end

  assign taken_o       = taken_reg;
  assign link_o        = link_reg;
  assign redirect_pc_o = redirect_pc_reg;

endmodule
